// File: rtl/conv3x3_multich_core.sv
// Multi-channel 3x3 "same" convolution core with valid/ready flow control,
// internal end-of-frame flush, fixed-point rescale, saturation and optional ReLU.
module conv3x3_multich_core #(
   parameter int P_WIDTH  = 16,
   parameter int P_HEIGHT = 16,
   parameter int CH_IN    = 1,
   parameter int DW       = 24,
   parameter int FRAC     = 8,
   parameter int RELU_EN  = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_din_valid,
   output logic                  o_din_ready,
   input  logic [CH_IN*DW-1:0]   i_din,
   input  logic [CH_IN*9*DW-1:0] i_w,
   input  logic [DW-1:0]         i_b,
   output logic [DW-1:0]         o_out,
   output logic                  o_out_valid,
   input  logic                  i_out_ready,
   output logic                  o_out_last_in_line,
   output logic                  o_out_last_pix
);
   localparam int NPIX = P_WIDTH * P_HEIGHT;
   localparam int SRL  = 2 * P_WIDTH + 3;
   localparam int CW   = $clog2(P_WIDTH);
   localparam int RW   = $clog2(P_HEIGHT);
   localparam int SW   = $clog2(NPIX + P_WIDTH + 1);
   localparam int PW   = 2 * DW;
   localparam int SUMW = 2 * DW + 4;
   localparam int AW   = 2 * DW + $clog2(9 * CH_IN) + 1;

   localparam logic [SW-1:0] C_FIRST_CEN = SW'(P_WIDTH + 1);
   localparam logic [SW-1:0] C_LAST_IN   = SW'(NPIX - 1);
   localparam logic [SW-1:0] C_LAST_FL   = SW'(NPIX + P_WIDTH);
   localparam logic [CW-1:0] C_LAST_COL  = CW'(P_WIDTH - 1);
   localparam logic [RW-1:0] C_LAST_ROW  = RW'(P_HEIGHT - 1);

   typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

   state_t                r_state;
   logic [SW-1:0]         r_shift_cnt;
   logic [RW-1:0]         r_cen_row, r_row0;
   logic [CW-1:0]         r_cen_col, r_col0;
   logic                  r_v0, r_v1, r_v2, r_v3;
   logic [1:0]            r_f1, r_f2, r_f3;
   logic signed [DW-1:0]  r_sr   [CH_IN][SRL];
   logic signed [DW-1:0]  w_tap  [CH_IN][9];
   logic signed [PW-1:0]  r_prod [CH_IN][9];
   logic signed [SUMW-1:0] w_csum [CH_IN];
   logic signed [SUMW-1:0] r_csum [CH_IN];
   logic signed [AW-1:0]  w_total, r_acc, w_scaled;
   logic                  w_en, w_accept, w_inject, w_shift, w_cen_ok;
   logic [2:0]            w_row_ok, w_col_ok;
   logic [1:0]            w_f0;

   // Saturate to the DW range, then optionally clamp negatives to zero.
   function automatic logic [DW-1:0] sat_relu(input logic signed [AW-1:0] v);
      logic signed [AW-1:0] v_max, v_min;
      logic [DW-1:0]        v_res;
      v_max = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
      v_min = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};
      if (v > v_max)      v_res = v_max[DW-1:0];
      else if (v < v_min) v_res = v_min[DW-1:0];
      else                v_res = v[DW-1:0];
      if ((RELU_EN != 0) && v_res[DW-1]) v_res = '0;
      return v_res;
   endfunction

   assign w_en        = ~o_out_valid | i_out_ready;
   assign o_din_ready = w_en & (r_state == ST_RUN);
   assign w_accept    = i_din_valid & o_din_ready;
   assign w_inject    = w_en & (r_state == ST_FLUSH);
   assign w_shift     = w_accept | w_inject;
   assign w_cen_ok    = (r_shift_cnt >= C_FIRST_CEN);

   // Line buffers and window as one shift chain per channel; contents never need clearing.
   always_ff @(posedge i_clk) begin
      if (w_shift) begin
         for (int c = 0; c < CH_IN; c++) begin
            r_sr[c][0] <= w_accept ? $signed(i_din[c*DW +: DW]) : '0;
            for (int s = 1; s < SRL; s++) r_sr[c][s] <= r_sr[c][s-1];
         end
      end
   end

   // Frame sequencing: shift count, RUN/FLUSH state and centre-pixel coordinates.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_RUN;
         r_shift_cnt <= '0;
         r_cen_row   <= '0;
         r_cen_col   <= '0;
         r_row0      <= '0;
         r_col0      <= '0;
         r_v0        <= 1'b0;
      end else if (w_en) begin
         r_v0 <= w_shift & w_cen_ok;
         if (w_shift) begin
            if (w_cen_ok) begin
               r_row0 <= r_cen_row;
               r_col0 <= r_cen_col;
               if (r_cen_col == C_LAST_COL) begin
                  r_cen_col <= '0;
                  r_cen_row <= (r_cen_row == C_LAST_ROW) ? '0 : r_cen_row + RW'(1);
               end else begin
                  r_cen_col <= r_cen_col + CW'(1);
               end
            end
            case (r_state)
               ST_RUN: begin
                  r_shift_cnt <= r_shift_cnt + SW'(1);
                  if (r_shift_cnt == C_LAST_IN) r_state <= ST_FLUSH;
               end
               ST_FLUSH: begin
                  if (r_shift_cnt == C_LAST_FL) begin
                     r_state     <= ST_RUN;
                     r_shift_cnt <= '0;
                  end else begin
                     r_shift_cnt <= r_shift_cnt + SW'(1);
                  end
               end
               default: begin
                  r_state     <= ST_RUN;
                  r_shift_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign w_row_ok = {r_row0 != C_LAST_ROW, 1'b1, r_row0 != '0};
   assign w_col_ok = {r_col0 != C_LAST_COL, 1'b1, r_col0 != '0};
   assign w_f0     = {(r_row0 == C_LAST_ROW) & (r_col0 == C_LAST_COL), r_col0 == C_LAST_COL};

   // Border mask: row 0 of the window is the oldest line, column 0 the leftmost pixel.
   always_comb begin
      for (int c = 0; c < CH_IN; c++) begin
         for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
               if (w_row_ok[i] && w_col_ok[j]) w_tap[c][3*i+j] = r_sr[c][(2-i)*P_WIDTH + (2-j)];
               else                            w_tap[c][3*i+j] = '0;
            end
         end
      end
   end

   // Channel sums, bias alignment and final rescale.
   always_comb begin
      for (int c = 0; c < CH_IN; c++) begin
         w_csum[c] = '0;
         for (int k = 0; k < 9; k++) w_csum[c] = w_csum[c] + SUMW'(r_prod[c][k]);
      end
      w_total = AW'($signed(i_b)) <<< FRAC;
      for (int c = 0; c < CH_IN; c++) w_total = w_total + AW'(r_csum[c]);
      w_scaled = r_acc >>> FRAC;
   end

   // Arithmetic pipeline S1..S3, advancing only when the output can move.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_v1 <= 1'b0; r_v2 <= 1'b0; r_v3 <= 1'b0;
         r_f1 <= 2'b00; r_f2 <= 2'b00; r_f3 <= 2'b00;
         r_acc <= '0;
         for (int c = 0; c < CH_IN; c++) begin
            r_csum[c] <= '0;
            for (int k = 0; k < 9; k++) r_prod[c][k] <= '0;
         end
      end else if (w_en) begin
         r_v1 <= r_v0; r_v2 <= r_v1; r_v3 <= r_v2;
         r_f1 <= w_f0; r_f2 <= r_f1; r_f3 <= r_f2;
         r_acc <= w_total;
         for (int c = 0; c < CH_IN; c++) begin
            r_csum[c] <= w_csum[c];
            for (int k = 0; k < 9; k++)
               r_prod[c][k] <= PW'(w_tap[c][k]) * PW'($signed(i_w[(c*9+k)*DW +: DW]));
         end
      end
   end

   // Output register: value and flags hold while downstream stalls.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_out              <= '0;
         o_out_valid        <= 1'b0;
         o_out_last_in_line <= 1'b0;
         o_out_last_pix     <= 1'b0;
      end else if (w_en) begin
         o_out_valid <= r_v3;
         if (r_v3) begin
            o_out              <= sat_relu(w_scaled);
            o_out_last_in_line <= r_f3[0];
            o_out_last_pix     <= r_f3[1];
         end else begin
            o_out              <= '0;
            o_out_last_in_line <= 1'b0;
            o_out_last_pix     <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_conv3x3_multich_core.sv
// Scoreboard bench for conv3x3_multich_core on 4x4 frames: one single-channel
// instance and one two-channel ReLU instance.
module tb_conv3x3_multich_core;
   typedef struct packed {logic [15:0] d; logic lil; logic lp;} exp_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         a_din_valid, a_din_ready, a_out_valid, a_out_ready, a_lil, a_lp;
   logic [15:0]  a_din, a_b, a_out;
   logic [143:0] a_w;
   logic         b_din_valid, b_din_ready, b_out_valid, b_out_ready, b_lil, b_lp;
   logic [31:0]  b_din;
   logic [15:0]  b_b, b_out;
   logic [287:0] b_w;

   exp_t qa[$];
   exp_t qb[$];
   exp_t ea, eb;
   int   n_chk = 0, n_pass = 0;
   int   cyc = 0, t_en = 0, lat_req = 0, lat_done = 0;
   bit   rnd_mode = 1'b0, a_pend = 1'b0;
   logic [17:0] a_hold;

   conv3x3_multich_core #(.P_WIDTH(4), .P_HEIGHT(4), .CH_IN(1), .DW(16), .FRAC(8), .RELU_EN(0)) u_a (
      .i_clk(clk), .i_rst(rst), .i_din_valid(a_din_valid), .o_din_ready(a_din_ready),
      .i_din(a_din), .i_w(a_w), .i_b(a_b), .o_out(a_out), .o_out_valid(a_out_valid),
      .i_out_ready(a_out_ready), .o_out_last_in_line(a_lil), .o_out_last_pix(a_lp));

   conv3x3_multich_core #(.P_WIDTH(4), .P_HEIGHT(4), .CH_IN(2), .DW(16), .FRAC(8), .RELU_EN(1)) u_b (
      .i_clk(clk), .i_rst(rst), .i_din_valid(b_din_valid), .o_din_ready(b_din_ready),
      .i_din(b_din), .i_w(b_w), .i_b(b_b), .o_out(b_out), .o_out_valid(b_out_valid),
      .i_out_ready(b_out_ready), .o_out_last_in_line(b_lil), .o_out_last_pix(b_lp));

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, req);
   endtask

   // Downstream ready: always 1, or a coin flip per cycle while rnd_mode is set.
   initial begin
      a_out_ready = 1'b1;
      b_out_ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         a_out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Monitor A: pops on each transfer, checks stability while stalled and first-output latency.
   always @(negedge clk) begin
      if (rst) begin
         a_pend = 1'b0;
      end else begin
         if (a_pend) check("A_hold", {13'd0, a_out_valid, a_out, a_lil, a_lp}, {13'd0, 1'b1, a_hold});
         if (lat_req != lat_done && a_out_valid) begin
            check("A_latency", cyc - t_en, 4);
            lat_done = lat_req;
         end
         if (a_out_valid && a_out_ready) begin
            a_pend = 1'b0;
            if (qa.size() == 0) begin
               n_chk++;
               $display("FAIL A_extra: unexpected output 0x%0h", a_out);
            end else begin
               ea = qa.pop_front();
               check("A_out", {14'd0, a_out, a_lil, a_lp}, {14'd0, ea.d, ea.lil, ea.lp});
            end
         end else if (a_out_valid) begin
            a_pend = 1'b1;
            a_hold = {a_out, a_lil, a_lp};
         end else begin
            a_pend = 1'b0;
         end
      end
   end

   // Monitor B: downstream always ready.
   always @(negedge clk) begin
      if (!rst && b_out_valid) begin
         if (qb.size() == 0) begin
            n_chk++;
            $display("FAIL B_extra: unexpected output 0x%0h", b_out);
         end else begin
            eb = qb.pop_front();
            check("B_out", {14'd0, b_out, b_lil, b_lp}, {14'd0, eb.d, eb.lil, eb.lp});
         end
      end
   end

   task automatic send(input bit sel, input logic [31:0] d);
      bit ok = 1'b0;
      if (sel) begin b_din = d; b_din_valid = 1'b1; end
      else begin a_din = d[15:0]; a_din_valid = 1'b1; end
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (sel ? b_din_ready : a_din_ready) begin ok = 1'b1; break; end
      end
      if (!ok) begin
         n_chk++;
         $display("FAIL send_timeout: din_ready stayed 0 for 200 cycles");
      end
      @(posedge clk); #1;
      a_din_valid = 1'b0;
      b_din_valid = 1'b0;
   endtask

   // kind 0: neighbour-count pattern (x1.0), kind 1: ramp + 0x80, kind 2: constant ev.
   task automatic frame(input bit sel, input int kind, input logic [31:0] dc, input logic [15:0] ev, input bit rnd);
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            int   k  = r * 4 + c;
            int   nb = (3 - int'(r == 0) - int'(r == 3)) * (3 - int'(c == 0) - int'(c == 3));
            exp_t e;
            e.d   = (kind == 0) ? 16'(nb * 256) : (kind == 1) ? 16'(k * 256 + 128) : ev;
            e.lil = (c == 3);
            e.lp  = (r == 3) && (c == 3);
            if (sel) qb.push_back(e); else qa.push_back(e);
         end
      end
      for (int k = 0; k < 16; k++) begin
         send(sel, (kind == 1) ? 32'(k * 256) : dc);
         if (kind == 1 && !rnd && k == 5) begin
            t_en = cyc;
            lat_req++;
         end
         if (rnd) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic drain(input bit sel);
      int t = 0;
      while ((sel ? qb.size() : qa.size()) != 0 && t < 500) begin
         @(posedge clk);
         t++;
      end
      if (t >= 500) begin
         n_chk++;
         $display("FAIL drain_timeout: %0d outputs missing", sel ? qb.size() : qa.size());
      end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic set_w_a(input logic [15:0] centre, input logic [15:0] other);
      for (int k = 0; k < 9; k++) a_w[k*16 +: 16] = (k == 4) ? centre : other;
   endtask

   task automatic set_w_b(input logic [15:0] w0, input logic [15:0] w1);
      for (int k = 0; k < 9; k++) begin
         b_w[k*16 +: 16]     = w0;
         b_w[(9+k)*16 +: 16] = w1;
      end
   endtask

   initial begin
      rst = 1'b1;
      a_din_valid = 1'b0; b_din_valid = 1'b0;
      a_din = '0; b_din = '0; a_w = '0; b_w = '0; a_b = '0; b_b = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
      check("rst_out", {16'd0, a_out}, 32'd0);
      check("rst_last_in_line", {31'd0, a_lil}, 32'd0);
      check("rst_last_pix", {31'd0, a_lp}, 32'd0);
      check("rst_din_ready", {31'd0, a_din_ready}, 32'd1);
      check("rst_b_out_valid", {31'd0, b_out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      // All-ones weights over constant 1.0 input
      set_w_a(16'h0100, 16'h0100); a_b = 16'h0000;
      frame(1'b0, 0, 32'h0000_0100, 16'h0000, 1'b0);
      drain(1'b0);

      // Identity kernel with bias, ramp input
      set_w_a(16'h0100, 16'h0000); a_b = 16'h0080;
      frame(1'b0, 1, 32'h0000_0000, 16'h0000, 1'b0);
      drain(1'b0);

      // Positive and negative saturation
      set_w_a(16'h7FFF, 16'h7FFF); a_b = 16'h0000;
      frame(1'b0, 2, 32'h0000_7FFF, 16'h7FFF, 1'b0);
      drain(1'b0);
      frame(1'b0, 2, 32'h0000_8000, 16'h8000, 1'b0);
      drain(1'b0);

      // Two back-to-back ramp frames under random backpressure and input gaps
      set_w_a(16'h0100, 16'h0000); a_b = 16'h0080;
      rnd_mode = 1'b1;
      frame(1'b0, 1, 32'h0000_0000, 16'h0000, 1'b1);
      frame(1'b0, 1, 32'h0000_0000, 16'h0000, 1'b1);
      rnd_mode = 1'b0;
      drain(1'b0);

      // Reset mid-frame, then a clean frame
      set_w_a(16'h0100, 16'h0100); a_b = 16'h0000;
      for (int k = 0; k < 7; k++) send(1'b0, 32'h0000_0100);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_out_valid", {31'd0, a_out_valid}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      frame(1'b0, 0, 32'h0000_0100, 16'h0000, 1'b0);
      drain(1'b0);

      // Two channels cancelling, then second channel weights zeroed
      set_w_b(16'h0100, 16'h0100); b_b = 16'h0000;
      frame(1'b1, 2, 32'hFF00_0100, 16'h0000, 1'b0);
      drain(1'b1);
      set_w_b(16'h0100, 16'h0000);
      frame(1'b1, 0, 32'hFF00_0100, 16'h0000, 1'b0);
      drain(1'b1);

      // Negative saturation clamped by ReLU
      set_w_b(16'h7FFF, 16'h0000);
      frame(1'b1, 2, 32'h0000_8000, 16'h0000, 1'b0);
      drain(1'b1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
